// File: rtl/vga.sv
// vga: 640x480@60 Hz display generator for the Breakout demo.
// Runs from the 50 MHz board clock; a toggling pixel enable gives the
// 25 MHz pixel rate. Draws a static brick wall, a paddle that tracks the
// ball, and a ball that bounces between the walls, the brick underside
// and the paddle line. The game state advances once per frame.
//
// Ports:
//   clk     50 MHz clock, rising edge
//   rst_n   asynchronous active-low reset
//   rgb     3-bit pixel colour {R,G,B}, 000 outside the visible area
//   hsync   horizontal sync, active low, decoded from hcount
//   vsync   vertical sync, active low, decoded from vcount
//   hcount  current pixel column, 0..H_total-1
//   vcount  current line, 0..V_total-1
module vga #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] rgb,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] hcount,
  output logic [9:0] vcount
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Scene geometry (screen pixels)
  localparam logic [9:0] STEP     = 10'd2;
  localparam logic [9:0] BALL_SZ  = 10'd8;
  localparam logic [9:0] X_MAX    = 10'd632;  // right wall minus ball size
  localparam logic [9:0] Y_MIN    = 10'd96;   // underside of the brick wall
  localparam logic [9:0] Y_MAX    = 10'd448;  // paddle top minus ball size
  localparam logic [9:0] PAD_W    = 10'd80;
  localparam logic [9:0] PAD_Y0   = 10'd456;
  localparam logic [9:0] PAD_Y1   = 10'd464;
  localparam logic [9:0] PAD_OFF  = 10'd36;   // centres paddle under ball
  localparam logic [9:0] PAD_MAX  = 10'd560;
  localparam logic [9:0] BRICK_Y0 = 10'd32;
  localparam logic [9:0] BRICK_Y1 = 10'd96;

  logic       pix_en;
  logic [9:0] ball_x, ball_y, paddle_x;
  logic       dir_x;  // 1 = moving right
  logic       dir_y;  // 1 = moving down

  logic [9:0] nx, ny, npx;
  logic       ndx, ndy;
  logic       frame_tick;

  // Game update point: first pixel of the first blanking line
  assign frame_tick = (hcount == '0) && (vcount == V_ACT);

  // Next ball position, bounce and paddle tracking
  always_comb begin
    nx  = ball_x;
    ny  = ball_y;
    ndx = dir_x;
    ndy = dir_y;
    npx = paddle_x;
    if (dir_x) begin
      if (ball_x == X_MAX) begin ndx = 1'b0; nx = ball_x - STEP; end
      else nx = ball_x + STEP;
    end else begin
      if (ball_x == '0) begin ndx = 1'b1; nx = ball_x + STEP; end
      else nx = ball_x - STEP;
    end
    if (dir_y) begin
      if (ball_y == Y_MAX) begin ndy = 1'b0; ny = ball_y - STEP; end
      else ny = ball_y + STEP;
    end else begin
      if (ball_y == Y_MIN) begin ndy = 1'b1; ny = ball_y + STEP; end
      else ny = ball_y - STEP;
    end
    // Compare before subtracting so a would-be negative offset clamps to 0
    if (nx < PAD_OFF)                npx = '0;
    else if (nx - PAD_OFF > PAD_MAX) npx = PAD_MAX;
    else                             npx = nx - PAD_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en   <= 1'b0;
      hcount   <= '0;
      vcount   <= '0;
      ball_x   <= 10'd316;
      ball_y   <= 10'd300;
      dir_x    <= 1'b1;
      dir_y    <= 1'b0;
      paddle_x <= 10'd280;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (hcount == H_LAST) begin
          hcount <= '0;
          vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
        if (frame_tick) begin
          ball_x   <= nx;
          ball_y   <= ny;
          dir_x    <= ndx;
          dir_y    <= ndy;
          paddle_x <= npx;
        end
      end
    end
  end

  assign hsync = !((hcount >= HS_BEG) && (hcount <= HS_END));
  assign vsync = !((vcount >= VS_BEG) && (vcount <= VS_END));

  logic ball_hit, pad_hit, brick_hit;

  assign ball_hit  = (hcount >= ball_x) && (hcount < ball_x + BALL_SZ) &&
                     (vcount >= ball_y) && (vcount < ball_y + BALL_SZ);
  assign pad_hit   = (hcount >= paddle_x) && (hcount < paddle_x + PAD_W) &&
                     (vcount >= PAD_Y0) && (vcount < PAD_Y1);
  // 64x16 brick cells with a 2-pixel mortar line on the left and top
  assign brick_hit = (vcount >= BRICK_Y0) && (vcount < BRICK_Y1) &&
                     (hcount[5:0] >= 6'd2) && (vcount[3:0] >= 4'd2);

  always_comb begin
    rgb = 3'b000;
    if ((hcount < H_ACT) && (vcount < V_ACT)) begin
      if (ball_hit)     rgb = 3'b101;
      else if (pad_hit) rgb = 3'b111;
      else if (brick_hit) begin
        // vcount 32..95 puts vcount[6:4] at 2..5, one value per brick row
        case (vcount[6:4])
          3'd2:    rgb = 3'b100;
          3'd3:    rgb = 3'b110;
          3'd4:    rgb = 3'b010;
          3'd5:    rgb = 3'b011;
          default: rgb = 3'b000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga.sv
// tb_vga: self-checking bench for vga.
// Three instances share one 50 MHz clock:
//   dut_a  standard 640x480 timing: reset, pixel rate, line timing, blanking
//   dut_c  short lines (128 visible, tiny porches) so the brick rows are
//          reached quickly with real vertical geometry
//   dut_b  4x4-pixel frames so hundreds of game updates run quickly
// The model derives every expected value from the number of clock edges
// since reset release: pixel index, counter position, number of completed
// game updates, and closed-form triangle-wave ball/paddle positions.
module tb_vga;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic [2:0] rgb_a, rgb_b, rgb_c;
  logic       hs_a, hs_b, hs_c, vs_a, vs_b, vs_c;
  logic [9:0] hc_a, hc_b, hc_c, vc_a, vc_b, vc_c;

  vga dut_a (.clk(clk), .rst_n(rst_a), .rgb(rgb_a), .hsync(hs_a), .vsync(vs_a),
             .hcount(hc_a), .vcount(vc_a));
  vga #(.H_ACTIVE(128), .H_FP(2), .H_SYNC(3), .H_BP(2))
      dut_c (.clk(clk), .rst_n(rst_c), .rgb(rgb_c), .hsync(hs_c), .vsync(vs_c),
             .hcount(hc_c), .vcount(vc_c));
  vga #(.H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1))
      dut_b (.clk(clk), .rst_n(rst_b), .rgb(rgb_b), .hsync(hs_b), .vsync(vs_b),
             .hcount(hc_b), .vcount(vc_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Ball bounces between x=0 and 632, starting at 316 moving right
  function automatic int bx_at(input int n);
    int u;
    u = (316 + 2 * n) % 1264;
    return (u <= 632) ? u : 1264 - u;
  endfunction

  // Ball bounces between y=96 and 448, starting at 300 moving up
  function automatic int by_at(input int n);
    int u;
    u = (204 - 2 * n) % 704;
    if (u < 0) u += 704;
    return 96 + ((u <= 352) ? u : 704 - u);
  endfunction

  function automatic int px_at(input int n);
    int t;
    t = bx_at(n) - 36;
    if (t < 0)   return 0;
    if (t > 560) return 560;
    return t;
  endfunction

  function automatic int rgb_at(input int h, input int v, input int n,
                                input int ha, input int va);
    int bx, by, px;
    bx = bx_at(n); by = by_at(n); px = px_at(n);
    if (h >= ha || v >= va) return 0;
    if (h >= bx && h < bx + 8 && v >= by && v < by + 8) return 5;
    if (h >= px && h < px + 80 && v >= 456 && v < 464) return 7;
    if (v >= 32 && v < 96 && (h % 64) >= 2 && (v % 16) >= 2)
      case ((v - 32) / 16)
        0:       return 4;
        1:       return 6;
        2:       return 2;
        default: return 3;
      endcase
    return 0;
  endfunction

  // Full output/state check for one sample, e = clock edges since release
  task automatic check_all(input string nm, input int e,
                           input int ha, input int hfp, input int hs, input int hbp,
                           input int va, input int vfp, input int vs, input int vbp,
                           input logic [9:0] hc, input logic [9:0] vc,
                           input logic hsy, input logic vsy, input logic [2:0] col,
                           input logic [9:0] bx, input logic [9:0] by,
                           input logic [9:0] px);
    int ht, vt, j, h, v, upd, n;
    ht  = ha + hfp + hs + hbp;
    vt  = va + vfp + vs + vbp;
    j   = e / 2;
    h   = j % ht;
    v   = (j / ht) % vt;
    upd = va * ht;
    n   = (j > upd) ? (j - 1 - upd) / (ht * vt) + 1 : 0;
    chk({nm, ".hcount"}, 32'(hc), h);
    chk({nm, ".vcount"}, 32'(vc), v);
    chk({nm, ".hsync"}, 32'(hsy), (h >= ha + hfp && h < ha + hfp + hs) ? 0 : 1);
    chk({nm, ".vsync"}, 32'(vsy), (v >= va + vfp && v < va + vfp + vs) ? 0 : 1);
    chk({nm, ".rgb"}, 32'(col), rgb_at(h, v, n, ha, va));
    chk({nm, ".ball_x"}, 32'(bx), bx_at(n));
    chk({nm, ".ball_y"}, 32'(by), by_at(n));
    chk({nm, ".paddle_x"}, 32'(px), px_at(n));
  endtask

  int ea, eb, ec;
  always @(posedge clk or negedge rst_a) if (!rst_a) ea <= 0; else ea <= ea + 1;
  always @(posedge clk or negedge rst_b) if (!rst_b) eb <= 0; else eb <= eb + 1;
  always @(posedge clk or negedge rst_c) if (!rst_c) ec <= 0; else ec <= ec + 1;

  logic on_a = 1'b0, on_b = 1'b0, on_c = 1'b0;
  int   hs_low_a = 0;

  // Standard timing instance
  always @(negedge clk) if (on_a) begin
    check_all("A", ea, 640, 16, 96, 48, 480, 10, 2, 33,
              hc_a, vc_a, hs_a, vs_a, rgb_a, dut_a.ball_x, dut_a.ball_y, dut_a.paddle_x);
    if (rst_a && ea < 1600 && !hs_a) hs_low_a++;
    if (!rst_a) begin
      chk("A.rst_hcount", 32'(hc_a), 0);
      chk("A.rst_paddle", 32'(dut_a.paddle_x), 280);
    end
    if (rst_a && ea == 1) chk("A.first_hcount", 32'(hc_a), 0);
    if (ea == 2)    chk("A.second_hcount", 32'(hc_a), 1);
    if (ea == 1400) chk("A.rgb_h700", 32'(rgb_a), 0);
    if (ea == 1312) chk("A.hsync_h656", 32'(hs_a), 0);
    if (ea == 1504) chk("A.hsync_h752", 32'(hs_a), 1);
    if (ea == 1600) begin
      chk("A.line_hcount", 32'(hc_a), 0);
      chk("A.line_vcount", 32'(vc_a), 1);
      chk("A.hsync_low_clks", 32'(hs_low_a), 192);
    end
  end

  // Brick-wall instance: (h, v, colour) spot checks
  int c_h [10] = '{100, 64, 66, 127, 128, 100, 100, 100, 100, 10};
  int c_v [10] = '{ 40, 40, 40,  40,  40,  49,  60,  70,  90, 20};
  int c_c [10] = '{  4,  0,  4,   4,   0,   0,   6,   2,   3,  0};

  always @(negedge clk) if (on_c) begin
    check_all("C", ec, 128, 2, 3, 2, 480, 10, 2, 33,
              hc_c, vc_c, hs_c, vs_c, rgb_c, dut_c.ball_x, dut_c.ball_y, dut_c.paddle_x);
    for (int i = 0; i < 10; i++)
      if (rst_c && ec == 2 * (c_v[i] * 135 + c_h[i]))
        chk($sformatf("C.pix_%0d_%0d", c_h[i], c_v[i]), 32'(rgb_c), c_c[i]);
  end

  // Motion instance: state after the n-th game update
  int b_n  [8] = '{  1, 102, 103, 158, 159, 457, 474, 475};
  int b_x  [8] = '{318, 520, 522, 632, 630,  34,   0,   2};
  int b_y  [8] = '{298,  96,  98, 208, 210, 102, 136, 138};
  int b_px [8] = '{282, 484, 486, 560, 560,   0,   0,   0};

  always @(negedge clk) if (on_b) begin
    check_all("B", eb, 1, 1, 1, 1, 1, 1, 1, 1,
              hc_b, vc_b, hs_b, vs_b, rgb_b, dut_b.ball_x, dut_b.ball_y, dut_b.paddle_x);
    // 4x4 frame = 16 pixels; update n lands on pixel 4 + (n-1)*16
    for (int i = 0; i < 8; i++)
      if (rst_b && eb == 2 * (4 + (b_n[i] - 1) * 16 + 1)) begin
        chk($sformatf("B.upd%0d_x", b_n[i]), 32'(dut_b.ball_x), b_x[i]);
        chk($sformatf("B.upd%0d_y", b_n[i]), 32'(dut_b.ball_y), b_y[i]);
        chk($sformatf("B.upd%0d_paddle", b_n[i]), 32'(dut_b.paddle_x), b_px[i]);
      end
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    fork
      begin
        repeat (2) @(negedge clk);
        #2 on_a = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_a = 1'b1;
        repeat (3400) @(negedge clk);
        #2 on_a = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        #2 on_c = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_c = 1'b1;
        repeat (24700) @(negedge clk);
        #2 on_c = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        #2 on_b = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_b = 1'b1;
        repeat (15433) @(negedge clk);
        // Reset in the middle of a frame, well after the ball has moved
        #5 rst_b = 1'b0;
        #1;
        chk("B.midrst_hcount", 32'(hc_b), 0);
        chk("B.midrst_vcount", 32'(vc_b), 0);
        chk("B.midrst_ball_x", 32'(dut_b.ball_x), 316);
        chk("B.midrst_ball_y", 32'(dut_b.ball_y), 300);
        chk("B.midrst_paddle", 32'(dut_b.paddle_x), 280);
        repeat (3) @(negedge clk);
        #2 rst_b = 1'b1;
        repeat (200) @(negedge clk);
        #2 on_b = 1'b0;
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
